// File: rtl/bram_pkg.sv
// Shared FSM encoding and default geometry for the bram_loader block.
package bram_pkg;

  localparam int DEF_VAR_WIDTH  = 32;
  localparam int DEF_ADD_WIDTH  = 10;
  localparam int DEF_PIPE_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    FETCH,
    WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/bram_loader.sv
// Streams words into a line-organised ram and optionally reads back whole lines.
// The line read-back path is built only when BRAM_LOADER_FETCH_EN is defined.
module bram_loader
  import bram_pkg::*;
#(
  parameter int varWIDTH   = DEF_VAR_WIDTH,
  parameter int ADD_WIDTH  = DEF_ADD_WIDTH,
  parameter int PIPE_WIDTH = DEF_PIPE_WIDTH,
  localparam int LW        = ADD_WIDTH - $clog2(PIPE_WIDTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADD_WIDTH-1:0]           base_add,
  input  logic [ADD_WIDTH:0]             count,
  input  logic                           in_valid,
  input  logic [varWIDTH-1:0]            in_data,
  output logic                           in_ready,
  output logic                           busy,
  output logic                           done,
  input  logic                           fetch_req,
  input  logic [LW-1:0]                  fetch_line,
  output logic                           line_valid,
  output logic [varWIDTH*PIPE_WIDTH-1:0] line_data,
  output logic [ADD_WIDTH-1:0]           ram_add,
  output logic [varWIDTH-1:0]            ram_data_in,
  output logic                           ram_cs,
  output logic                           ram_we,
  output logic                           ram_oe,
  input  logic [varWIDTH*PIPE_WIDTH-1:0] ram_data_out
);

  // Word stream: a word transfers on a rising edge where in_valid and in_ready
  // are both high; in_data is don't-care otherwise and in_valid never waits on in_ready.

  state_t                 state, state_n;
  logic [ADD_WIDTH-1:0]   ptr, ptr_n;
  logic [ADD_WIDTH:0]     remaining, remaining_n;
  logic [ADD_WIDTH-1:0]   ram_add_n;
  logic [varWIDTH-1:0]    ram_data_in_n;
  logic                   ram_cs_n, ram_we_n, ram_oe_n;
  logic                   done_n, busy_n;

`ifdef BRAM_LOADER_FETCH_EN
  logic                            wait_cnt, wait_cnt_n;
  logic                            line_valid_n;
  logic [varWIDTH*PIPE_WIDTH-1:0]  line_data_n;
`endif

  assign in_ready = (state == LOAD) && (remaining != '0);

  always_comb begin
    state_n       = state;
    ptr_n         = ptr;
    remaining_n   = remaining;
    ram_add_n     = ram_add;
    ram_data_in_n = ram_data_in;
    ram_cs_n      = 1'b0;
    ram_we_n      = 1'b0;
    ram_oe_n      = 1'b0;
`ifdef BRAM_LOADER_FETCH_EN
    wait_cnt_n    = wait_cnt;
    line_valid_n  = 1'b0;
    line_data_n   = line_data;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            ptr_n       = base_add;
            remaining_n = count;
            state_n     = LOAD;
          end else begin
            state_n = DONE;
          end
        end
`ifdef BRAM_LOADER_FETCH_EN
        else if (fetch_req) begin
          ram_cs_n  = 1'b1;
          ram_oe_n  = 1'b1;
          ram_add_n = ADD_WIDTH'(fetch_line) << $clog2(PIPE_WIDTH);
          state_n   = FETCH;
        end
`endif
      end
      LOAD: begin
        if (in_valid && in_ready) begin
          ram_cs_n      = 1'b1;
          ram_we_n      = 1'b1;
          ram_add_n     = ptr;
          ram_data_in_n = in_data;
          ptr_n         = ptr + ADD_WIDTH'(1);
          remaining_n   = remaining - (ADD_WIDTH+1)'(1);
          if (remaining == (ADD_WIDTH+1)'(1)) state_n = DRAIN;
        end
      end
      DRAIN: state_n = DONE;
`ifdef BRAM_LOADER_FETCH_EN
      FETCH: begin
        wait_cnt_n = 1'b0;
        state_n    = WAIT;
      end
      // Two WAIT cycles cover a ram with a registered output stage.
      WAIT: begin
        if (wait_cnt) begin
          line_data_n  = ram_data_out;
          line_valid_n = 1'b1;
          state_n      = DONE;
        end else begin
          wait_cnt_n = 1'b1;
        end
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    done_n = (state_n == DONE);
    busy_n = (state_n != IDLE) && (state_n != DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      remaining   <= '0;
      ram_add     <= '0;
      ram_data_in <= '0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      remaining   <= remaining_n;
      ram_add     <= ram_add_n;
      ram_data_in <= ram_data_in_n;
      ram_cs      <= ram_cs_n;
      ram_we      <= ram_we_n;
      ram_oe      <= ram_oe_n;
      done        <= done_n;
      busy        <= busy_n;
    end
  end

`ifdef BRAM_LOADER_FETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt   <= 1'b0;
      line_valid <= 1'b0;
      line_data  <= '0;
    end else begin
      wait_cnt   <= wait_cnt_n;
      line_valid <= line_valid_n;
      line_data  <= line_data_n;
    end
  end
`else
  assign line_valid = 1'b0;
  assign line_data  = '0;

  logic unused_fetch;
  assign unused_fetch = ^{fetch_req, fetch_line, ram_data_out};
`endif

endmodule

// File: tb/tb_bram_loader.sv
// Directed bench for bram_loader: table of load commands plus hand sequences
// for fetch read-back (BRAM_LOADER_FETCH_EN) and reset in the middle of a load.
module tb_bram_loader;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int PW = 16;
  localparam int LW = AW - $clog2(PW);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [AW-1:0]     base_add;
  logic [AW:0]       count;
  logic              in_valid;
  logic [W-1:0]      in_data;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic              fetch_req;
  logic [LW-1:0]     fetch_line;
  logic              line_valid;
  logic [W*PW-1:0]   line_data;
  logic [AW-1:0]     ram_add;
  logic [W-1:0]      ram_data_in;
  logic              ram_cs, ram_we, ram_oe;
  logic [W*PW-1:0]   ram_data_out;

  bram_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_add(base_add), .count(count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .busy(busy),
    .done(done), .fetch_req(fetch_req), .fetch_line(fetch_line),
    .line_valid(line_valid), .line_data(line_data), .ram_add(ram_add),
    .ram_data_in(ram_data_in), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_data_out(ram_data_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  // ram model: synchronous write, synchronous whole-line read
  logic [W-1:0]    mem [0:(1<<AW)-1];
  logic [W*PW-1:0] rd_q;
  assign ram_data_out = rd_q;
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_add] <= ram_data_in;
    if (ram_cs && ram_oe)
      for (int k = 0; k < PW; k++) rd_q[k*W +: W] <= mem[ram_add + AW'(k)];
  end

  // scoreboard state
  logic [AW+W-1:0] exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [AW-1:0] ptr_model;
  logic prev_acc, last_acc, last_done, last_busy;
  logic rdy_seen, oe_seen;
  int   wr_cnt, done_cnt, bad_timing;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    logic [3:0]    pat;
    logic [W-1:0]  dbase;
    logic          fetch_too;
    int            exp_done;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_counters();
    wr_cnt = 0; done_cnt = 0; bad_timing = 0;
    rdy_seen = 1'b0; oe_seen = 1'b0; prev_acc = 1'b0;
  endtask

  // One clock: drive the word stream, check strobes at the negedge, move past next edge.
  task automatic tick(input logic v, input logic [W-1:0] d);
    logic acc;
    logic [AW+W-1:0] e;
    in_valid = v;
    in_data  = d;
    @(negedge clk);
    acc = in_valid && in_ready;
    if (in_ready) rdy_seen = 1'b1;
    if (ram_oe) oe_seen = 1'b1;
    if ((ram_cs && ram_we) != prev_acc) bad_timing++;
    if (ram_cs && ram_we) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL spurious_write: got add 0x%0h data 0x%0h expected no write", ram_add, ram_data_in);
      end else begin
        e = exp_q.pop_front();
        check("write_add_data", 64'({ram_add, ram_data_in}), 64'(e));
      end
    end
    if (acc) begin
      exp_q.push_back({ptr_model, d});
      ptr_model = ptr_model + AW'(1);
    end
    prev_acc  = acc;
    last_acc  = acc;
    last_done = done;
    last_busy = busy;
    if (done) done_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, 64'({in_ready, busy, done, line_valid, ram_cs, ram_we, ram_oe}), 64'd0);
    check({tag, "_ram_add"}, 64'(ram_add), 64'd0);
    check({tag, "_ram_data_in"}, 64'(ram_data_in), 64'd0);
    check({tag, "_line_data_nonzero"}, 64'(line_data != '0), 64'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int sent, done_at;
    clear_counters();
    start = 1'b1; base_add = v.base; count = v.cnt;
    fetch_req = v.fetch_too; fetch_line = LW'(3);
    @(posedge clk);
    #1;
    start = 1'b0; fetch_req = 1'b0;
    ptr_model = v.base;
    sent = 0;
    done_at = -1;
    for (int c = 0; c < 60 && done_at < 0; c++) begin
      tick((sent < int'(v.cnt)) && v.pat[c % 4], v.dbase + W'(sent));
      if (c == 0) check("busy_first", 64'(last_busy), 64'(v.cnt != '0));
      if (last_acc) sent++;
      if (last_done) done_at = c;
    end
    check("done_latency", 64'(done_at), 64'(v.exp_done));
    tick(1'b0, '0);
    tick(1'b0, '0);
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("write_count", 64'(wr_cnt), 64'(v.cnt));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("busy_after", 64'(last_busy), 64'd0);
    check("in_ready_seen", 64'(rdy_seen), 64'(v.cnt != '0));
    check("oe_seen", 64'(oe_seen), 64'd0);
    check("strobe_timing", 64'(bad_timing), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lv_at, lv_cnt;
    logic fetch_done;

    // base, count, in_valid pattern (bit = cycle%4), first data word, fetch_req too, done edge
    vecs[0] = '{10'h005, 11'd3,  4'b1111, 32'h0000_000A, 1'b0, 4};
    vecs[1] = '{10'h3FF, 11'd2,  4'b1111, 32'h0000_0100, 1'b0, 3};
    vecs[2] = '{10'h123, 11'd0,  4'b1111, 32'h0000_0000, 1'b0, 0};
    vecs[3] = '{10'h040, 11'd2,  4'b0101, 32'h0000_0200, 1'b0, 4};
    vecs[4] = '{10'h010, 11'd16, 4'b1111, 32'h0000_0010, 1'b0, 17};
    vecs[5] = '{10'h200, 11'd5,  4'b0011, 32'h0000_0300, 1'b0, 10};
    vecs[6] = '{10'h0AA, 11'd1,  4'b1111, 32'h0000_0077, 1'b1, 2};

    rst_n = 1'b0; start = 1'b0; base_add = '0; count = '0;
    in_valid = 1'b0; in_data = '0; fetch_req = 1'b0; fetch_line = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // words offered while idle must not be consumed
    clear_counters();
    ptr_model = '0;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'hDEAD_0000 + W'(i));
    in_valid = 1'b0;
    check("idle_writes", 64'(wr_cnt), 64'd0);
    check("idle_in_ready", 64'(rdy_seen), 64'd0);
    check("idle_busy", 64'(last_busy), 64'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

`ifdef BRAM_LOADER_FETCH_EN
    // line 1 holds words 0x10..0x1F written by vecs[4]
    fetch_line = LW'(1);
    fetch_req  = 1'b1;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    check("fetch_strobe", 64'({ram_cs, ram_we, ram_oe}), 64'b101);
    check("fetch_add", 64'(ram_add), 64'h010);
    check("fetch_busy", 64'(busy), 64'd1);
    lv_at = -1; lv_cnt = 0; fetch_done = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) check("fetch_strobe_end", 64'(ram_cs), 64'd0);
      if (line_valid) begin
        lv_cnt++;
        if (lv_at < 0) begin
          lv_at = c;
          fetch_done = done;
        end
      end
    end
    check("fetch_latency", 64'(lv_at), 64'd3);
    check("line_valid_pulses", 64'(lv_cnt), 64'd1);
    check("fetch_done", 64'(fetch_done), 64'd1);
    for (int k = 0; k < PW; k++)
      check("line_word", 64'(line_data[k*W +: W]), 64'(32'h10 + k));
`else
    fetch_line = LW'(1);
    fetch_req  = 1'b1;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    lv_cnt = 0; lv_at = 0;
    for (int c = 0; c < 6; c++) begin
      if (line_valid) lv_cnt++;
      if (busy || ram_cs || done) lv_at++;
      @(posedge clk);
      #1;
    end
    check("nofetch_line_valid", 64'(lv_cnt), 64'd0);
    check("nofetch_activity", 64'(lv_at), 64'd0);
    check("nofetch_line_data", 64'(line_data != '0), 64'd0);
`endif

    // reset after three of eight words have been written
    clear_counters();
    start = 1'b1; base_add = 10'h300; count = 11'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    ptr_model = 10'h300;
    tick(1'b1, 32'h55);
    tick(1'b1, 32'h56);
    tick(1'b1, 32'h57);
    tick(1'b0, 32'h58);
    check("midload_busy", 64'(last_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload");
    check("midload_writes", 64'(wr_cnt), 64'd3);
    check("midload_queue", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check("mem_300", 64'(mem[10'h300]), 64'h55);
    check("mem_301", 64'(mem[10'h301]), 64'h56);
    check("mem_302", 64'(mem[10'h302]), 64'h57);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    prev_acc = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h59);
    in_valid = 1'b0;
    check("midload_no_done", 64'(done_cnt), 64'd0);
    check("midload_no_more_writes", 64'(wr_cnt), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
